gcm_stream_packer: RTL and testbench
====================================

GCM_STREAM_PACKER -- requirements
Module: gcm_stream_packer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The port iClk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-003 The port iRst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-004 The port iStart SHALL be an input, 1 bit wide; a one-cycle pulse begins a new message and clears all counters and buffers.
REQ-005 The port iData SHALL be an input, [0:31]; it carries a big-endian word, and byte 0 is bits [0:7].
REQ-006 The port iData_valid SHALL be an input, 1 bit wide, and qualifies iData.
REQ-007 The port iData_type SHALL be an input, 1 bit wide: 0 = AAD, 1 = payload.
REQ-008 The port iData_last SHALL be an input, 1 bit wide, and marks the last word of the current segment.
REQ-009 The port iData_nbytes SHALL be an input, 3 bits wide, giving the valid bytes (1-4) of the last word; it is ignored unless iData_last=1.
REQ-010 The port oData_ready SHALL be an output, 1 bit wide; a word transfers when iData_valid & oData_ready.
REQ-011 The port iCore_ready SHALL be an input, 1 bit wide: the downstream GCM core accepts output this cycle.
REQ-012 The outputs oAad[0:127], oAad_valid and oAad_last SHALL present AAD blocks, and then the length block, to the core.
REQ-013 The outputs oBlock[0:127], oBlock_valid and oBlock_last SHALL present payload blocks to the core.
REQ-014 The output oBusy SHALL be 1 bit wide and high from iStart until the length block transfers.
REQ-015 The output oError SHALL be 1 bit wide, a sticky protocol-error flag cleared by iStart or iRst.

Function
REQ-016 The FSM SHALL have the states IDLE, AAD_FILL, AAD_SEND, PT_FILL, PT_SEND, LEN_SEND.
REQ-017 On iStart, the FSM SHALL go to AAD_FILL, clear the 128-bit buffer and 2-bit word index, and clear the 64-bit counters len_a and len_c.
REQ-018 oData_ready SHALL be 1 only in AAD_FILL and PT_FILL, and 0 in every other state.
REQ-019 Each accepted word SHALL be written to buffer bits [32*idx : 32*idx+31], and idx SHALL then increment.
REQ-020 Bytes beyond iData_nbytes in a last word SHALL be forced to zero, and unfilled words of a partial block SHALL be zero.
REQ-021 len_a or len_c SHALL add 8*bytes per accepted word (32, or 8*iData_nbytes on last), modulo 2^64.
REQ-022 Accepting the 4th word or a last word SHALL move AAD_FILL to AAD_SEND (or PT_FILL to PT_SEND) on the next edge; the output valid then asserts, giving 1-cycle latency.
REQ-023 In any SEND state, the output data and valid SHALL hold stable until iCore_ready=1 while valid=1.
REQ-024 On that transfer, the buffer and idx SHALL clear; the FSM SHALL return to FILL, or to PT_FILL after the last AAD block, or to LEN_SEND after the last payload block.
REQ-025 oAad_last SHALL be 1 on the final AAD block only, and oBlock_last SHALL be 1 on the final payload block only.
REQ-026 An empty AAD SHALL be handled this way: a payload-type word accepted in AAD_FILL with idx=0 and len_a=0 goes directly into PT_FILL handling, and no AAD block is emitted.
REQ-027 In LEN_SEND, oAad SHALL be {len_a[63:0], len_c[63:0]} with oAad_valid=1 and oAad_last=0; on transfer the FSM SHALL go to IDLE and oBusy SHALL fall.
REQ-028 The following SHALL be protocol errors: an AAD word in PT_FILL; a payload word in AAD_FILL with len_a>0 or idx>0 before the AAD last; iData_nbytes of 0 or >4 with last. On any of these, the word is dropped and oError is set.
REQ-029 iStart in any non-IDLE state SHALL abort the message and restart per REQ-017; any pending output SHALL be withdrawn the next cycle.
REQ-030 iStart and iData_valid in the same cycle SHALL restart the message first and SHALL NOT accept the data word.
REQ-031 iData_valid in IDLE SHALL be ignored, with no error.

Reset
REQ-032 iRst SHALL set the state to IDLE and clear buffer, idx, len_a and len_c.
REQ-033 iRst SHALL drive oData_ready, every valid/last output, oBusy and oError to 0.
REQ-034 iRst SHALL take priority over iStart.

Verification
REQ-035 The bench SHALL cover: 4 AAD words (last), then 8 payload words (last on 8th), with iCore_ready tied high -> one AAD block (last=1), two payload blocks (second last=1), and a length block of 0x80 || 0x100.
REQ-036 The bench SHALL cover: no AAD, then 5 payload words with nbytes=2 on the last -> two payload blocks; the second carries word0 bytes 0-1, and the rest is zero; length block 0 || 0x90; no oAad_valid before the length block.
REQ-037 The bench SHALL cover: iCore_ready low for 10 cycles during PT_SEND -> oBlock and oBlock_valid are stable and oData_ready=0 throughout; exactly one transfer occurs.
REQ-038 The bench SHALL cover: an AAD word sent after the payload has started -> oError=1, the word is dropped, and len_a is unchanged; the next iStart clears oError.
REQ-039 The bench SHALL cover: iStart pulsed mid-payload with 2 words buffered -> the next cycle has all valid outputs 0, the state is AAD_FILL and the counters are 0; a fresh message completes correctly.
REQ-040 The bench SHALL cover: iRst asserted in LEN_SEND concurrently with iStart -> all outputs are 0, the state is IDLE and oBusy=0.

Source files
------------

// File: rtl/gcm_stream_packer_if.sv
// Stream-side and core-side signal bundle for gcm_stream_packer.
// Word data and blocks are big-endian: bit 0 is the first bit on the wire.
interface gcm_stream_packer_if;
  logic         iStart;
  logic [0:31]  iData;
  logic         iData_valid;
  logic         iData_type;
  logic         iData_last;
  logic [2:0]   iData_nbytes;
  logic         oData_ready;
  logic         iCore_ready;
  logic [0:127] oAad;
  logic         oAad_valid;
  logic         oAad_last;
  logic [0:127] oBlock;
  logic         oBlock_valid;
  logic         oBlock_last;
  logic         oBusy;
  logic         oError;

  modport master (
    output iStart, iData, iData_valid, iData_type, iData_last, iData_nbytes, iCore_ready,
    input  oData_ready, oAad, oAad_valid, oAad_last, oBlock, oBlock_valid, oBlock_last,
    input  oBusy, oError
  );

  modport slave (
    input  iStart, iData, iData_valid, iData_type, iData_last, iData_nbytes, iCore_ready,
    output oData_ready, oAad, oAad_valid, oAad_last, oBlock, oBlock_valid, oBlock_last,
    output oBusy, oError
  );
endinterface

// File: rtl/gcm_stream_packer.sv
// Packs 32-bit AAD/payload words into 128-bit GCM blocks and appends the
// len(A)||len(C) block once the payload ends.
module gcm_stream_packer (
  input logic                iClk,
  input logic                iRst,
  gcm_stream_packer_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] AAD_FILL = 3'd1;
  localparam logic [2:0] AAD_SEND = 3'd2;
  localparam logic [2:0] PT_FILL  = 3'd3;
  localparam logic [2:0] PT_SEND  = 3'd4;
  localparam logic [2:0] LEN_SEND = 3'd5;

  logic [2:0]   state;
  logic [0:127] data_buf;
  logic [1:0]   idx;
  logic [63:0]  len_a;
  logic [63:0]  len_c;
  logic         last_blk;
  logic         error;

  logic         accept;
  logic         nbytes_bad;
  logic         empty_aad;
  logic         take_aad;
  logic         take_pt;
  logic         proto_err;
  logic [0:31]  masked;
  logic [63:0]  bit_count;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    accept     = bus.iData_valid && bus.oData_ready && !bus.iStart;
    nbytes_bad = bus.iData_last && (bus.iData_nbytes == 3'd0 || bus.iData_nbytes > 3'd4);
    empty_aad  = (state == AAD_FILL) && (idx == 2'd0) && (len_a == 64'd0);
    take_aad   = accept && !nbytes_bad && (state == AAD_FILL) && !bus.iData_type;
    // A payload word with nothing buffered and no AAD counted means the AAD was empty.
    take_pt    = accept && !nbytes_bad && bus.iData_type && ((state == PT_FILL) || empty_aad);
    proto_err  = accept && !take_aad && !take_pt;

    masked = bus.iData;
    if (bus.iData_last) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= int'(bus.iData_nbytes)) masked[8*b +: 8] = 8'h00;
      end
    end
    bit_count = bus.iData_last ? {58'd0, bus.iData_nbytes, 3'd0} : 64'd32;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data_buf is a flop array (not a RAM), so clearing it on reset/start is cheap and keeps padding zero.
  always_ff @(posedge iClk) begin
    if (iRst || bus.iStart) begin
      state    <= iRst ? IDLE : AAD_FILL;
      data_buf <= '0;
      idx      <= 2'd0;
      len_a    <= 64'd0;
      len_c    <= 64'd0;
      last_blk <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (proto_err) error <= 1'b1;
      case (state)
        AAD_FILL, PT_FILL: begin
          if (take_aad || take_pt) begin
            data_buf[{idx, 5'd0} +: 32] <= masked;
            idx      <= idx + 2'd1;
            last_blk <= bus.iData_last;
            if (take_aad) len_a <= len_a + bit_count;
            else          len_c <= len_c + bit_count;
            if (idx == 2'd3 || bus.iData_last) state <= take_aad ? AAD_SEND : PT_SEND;
            else                               state <= take_aad ? AAD_FILL : PT_FILL;
          end
        end
        AAD_SEND: begin
          if (bus.iCore_ready) begin
            data_buf <= '0;
            idx      <= 2'd0;
            state    <= last_blk ? PT_FILL : AAD_FILL;
          end
        end
        PT_SEND: begin
          if (bus.iCore_ready) begin
            data_buf <= '0;
            idx      <= 2'd0;
            state    <= last_blk ? LEN_SEND : PT_FILL;
          end
        end
        LEN_SEND: begin
          if (bus.iCore_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oData_ready  = (state == AAD_FILL) || (state == PT_FILL);
  assign bus.oAad         = (state == LEN_SEND) ? {len_a, len_c} : data_buf;
  assign bus.oAad_valid   = (state == AAD_SEND) || (state == LEN_SEND);
  assign bus.oAad_last    = (state == AAD_SEND) && last_blk;
  assign bus.oBlock       = data_buf;
  assign bus.oBlock_valid = (state == PT_SEND);
  assign bus.oBlock_last  = (state == PT_SEND) && last_blk;
  assign bus.oBusy        = (state != IDLE);
  assign bus.oError       = error;

endmodule

// File: tb/tb_gcm_stream_packer.sv
// Directed bench for gcm_stream_packer: block packing, padding, stalls,
// protocol errors, mid-message restart and reset priority.
module tb_gcm_stream_packer;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_AAD_FILL = 3'd1;
  localparam logic [2:0] S_PT_FILL  = 3'd3;
  localparam logic [2:0] S_PT_SEND  = 3'd4;
  localparam logic [2:0] S_LEN_SEND = 3'd5;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [128:0] aad_q[$];
  logic [128:0] blk_q[$];
  logic [127:0] exp_blk;
  logic [127:0] held;

  gcm_stream_packer_if bus ();

  gcm_stream_packer dut (.iClk(iClk), .iRst(iRst), .bus(bus.slave));

  always #5 iClk = ~iClk;

  // Record every transfer the core would see.
  always @(posedge iClk) begin
    if (bus.oAad_valid && bus.iCore_ready)   aad_q.push_back({bus.oAad_last, bus.oAad});
    if (bus.oBlock_valid && bus.iCore_ready) blk_q.push_back({bus.oBlock_last, bus.oBlock});
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic t, input logic [31:0] d, input logic l, input logic [2:0] nb);
    int n = 0;
    while (!bus.oData_ready && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check("ready_wait", bus.oData_ready, 1);
    bus.iData_valid  = 1'b1;
    bus.iData_type   = t;
    bus.iData        = d;
    bus.iData_last   = l;
    bus.iData_nbytes = nb;
    @(posedge iClk);
    @(negedge iClk);
    bus.iData_valid = 1'b0;
    bus.iData_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.oBusy && n < 100) begin
      @(negedge iClk);
      n++;
    end
    check("idle_wait", bus.oBusy, 0);
  endtask

  initial begin
    bus.iStart = 0; bus.iData = '0; bus.iData_valid = 0; bus.iData_type = 0;
    bus.iData_last = 0; bus.iData_nbytes = 3'd0; bus.iCore_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    check("rst_ready", bus.oData_ready, 0);
    check("rst_aad_valid", bus.oAad_valid, 0);
    check("rst_blk_valid", bus.oBlock_valid, 0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_error", bus.oError, 0);

    // Four AAD words then eight payload words, core always ready
    pulse_start();
    check("start_busy", bus.oBusy, 1);
    push(0, 32'hA0A1A2A3, 0, 3'd4);
    push(0, 32'hB0B1B2B3, 0, 3'd4);
    push(0, 32'hC0C1C2C3, 0, 3'd4);
    push(0, 32'hD0D1D2D3, 1, 3'd4);
    for (int i = 0; i < 8; i++) push(1, 32'h10000000 + i, (i == 7), 3'd4);
    wait_idle();
    check("s1_aad_n", aad_q.size(), 2);
    check("s1_aad_data", aad_q[0][127:0], 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
    check("s1_aad_last", aad_q[0][128], 1);
    check("s1_len_data", aad_q[1][127:0], {64'h80, 64'h100});
    check("s1_len_last", aad_q[1][128], 0);
    check("s1_blk_n", blk_q.size(), 2);
    check("s1_blk0", blk_q[0][127:0], 128'h10000000_10000001_10000002_10000003);
    check("s1_blk0_last", blk_q[0][128], 0);
    check("s1_blk1", blk_q[1][127:0], 128'h10000004_10000005_10000006_10000007);
    check("s1_blk1_last", blk_q[1][128], 1);

    // Data while idle is ignored without error
    bus.iData_valid = 1'b1; bus.iData_type = 1'b0; bus.iData = 32'h12345678;
    @(posedge iClk);
    @(negedge iClk);
    bus.iData_valid = 1'b0;
    check("idle_err", bus.oError, 0);
    check("idle_state", dut.state, S_IDLE);

    // Empty AAD, five payload words, last one holds two bytes
    aad_q.delete(); blk_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) push(1, 32'h20000000 + i, 0, 3'd4);
    push(1, 32'hC1C2C3C4, 1, 3'd2);
    wait_idle();
    check("s2_aad_n", aad_q.size(), 1);
    check("s2_len", aad_q[0][127:0], {64'h0, 64'h90});
    check("s2_blk_n", blk_q.size(), 2);
    check("s2_blk0", blk_q[0][127:0], 128'h20000000_20000001_20000002_20000003);
    check("s2_blk1", blk_q[1][127:0], 128'hC1C20000_00000000_00000000_00000000);
    check("s2_blk1_last", blk_q[1][128], 1);

    // Core stalls ten cycles with a payload block pending
    aad_q.delete(); blk_q.delete();
    bus.iCore_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) push(1, 32'h30000000 + i, 0, 3'd4);
    exp_blk = 128'h30000000_30000001_30000002_30000003;
    held = exp_blk;
    for (int c = 0; c < 10; c++) begin
      check("stall_data", bus.oBlock, held);
      check("stall_valid", bus.oBlock_valid, 1);
      check("stall_ready", bus.oData_ready, 0);
      @(negedge iClk);
    end
    bus.iCore_ready = 1'b1;
    @(negedge iClk);
    bus.iCore_ready = 1'b0;
    check("stall_xfers", blk_q.size(), 1);
    check("stall_state", dut.state, S_PT_FILL);

    // AAD word after payload has started is dropped and flagged
    push(0, 32'hEEEEEEEE, 1, 3'd4);
    check("err_flag", bus.oError, 1);
    check("err_len_a", dut.len_a, 0);
    check("err_len_c", dut.len_c, 128);
    check("err_idx", dut.idx, 0);
    check("err_state", dut.state, S_PT_FILL);
    pulse_start();
    check("err_cleared", bus.oError, 0);

    // Restart mid-payload with two words buffered
    bus.iCore_ready = 1'b1;
    push(0, 32'hDEADBEEF, 1, 3'd3);
    push(1, 32'h50000000, 0, 3'd4);
    push(1, 32'h50000001, 0, 3'd4);
    check("pre_restart_len_a", dut.len_a, 24);
    pulse_start();
    check("rs_aad_valid", bus.oAad_valid, 0);
    check("rs_blk_valid", bus.oBlock_valid, 0);
    check("rs_state", dut.state, S_AAD_FILL);
    check("rs_len_a", dut.len_a, 0);
    check("rs_len_c", dut.len_c, 0);
    check("rs_idx", dut.idx, 0);
    aad_q.delete(); blk_q.delete();
    push(0, 32'h01020304, 0, 3'd4);
    push(0, 32'h05060708, 1, 3'd1);
    push(1, 32'h0A0B0C0D, 1, 3'd4);
    wait_idle();
    check("rs_aad_n", aad_q.size(), 2);
    check("rs_aad_blk", aad_q[0][127:0], 128'h01020304_05000000_00000000_00000000);
    check("rs_aad_last", aad_q[0][128], 1);
    check("rs_len_blk", aad_q[1][127:0], {64'h28, 64'h20});
    check("rs_blk_n", blk_q.size(), 1);
    check("rs_blk", blk_q[0][127:0], 128'h0A0B0C0D_00000000_00000000_00000000);
    check("rs_blk_last", blk_q[0][128], 1);

    // Reset beats start while the length block is pending
    bus.iCore_ready = 1'b0;
    pulse_start();
    push(1, 32'h40414243, 1, 3'd4);
    bus.iCore_ready = 1'b1;
    @(negedge iClk);
    bus.iCore_ready = 1'b0;
    check("len_state", dut.state, S_LEN_SEND);
    check("len_valid", bus.oAad_valid, 1);
    check("len_value", bus.oAad, {64'h0, 64'h20});
    iRst = 1'b1; bus.iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0; bus.iStart = 1'b0;
    check("rp_ready", bus.oData_ready, 0);
    check("rp_aad_valid", bus.oAad_valid, 0);
    check("rp_aad_last", bus.oAad_last, 0);
    check("rp_blk_valid", bus.oBlock_valid, 0);
    check("rp_blk_last", bus.oBlock_last, 0);
    check("rp_busy", bus.oBusy, 0);
    check("rp_error", bus.oError, 0);
    check("rp_state", dut.state, S_IDLE);

    // Bad byte count and payload before AAD end are errors
    bus.iCore_ready = 1'b1;
    pulse_start();
    push(0, 32'h55555555, 1, 3'd0);
    check("nb0_err", bus.oError, 1);
    check("nb0_len_a", dut.len_a, 0);
    check("nb0_state", dut.state, S_AAD_FILL);
    pulse_start();
    push(0, 32'h66666666, 0, 3'd4);
    push(1, 32'h77777777, 0, 3'd4);
    check("early_pt_err", bus.oError, 1);
    check("early_pt_len_a", dut.len_a, 32);
    check("early_pt_len_c", dut.len_c, 0);
    check("early_pt_idx", dut.idx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
